neuron_weight_sequencer: RTL

Producer side of the neuron accumulator's control/weight stream. Accepts one input-spike frame of NA codes, then emits NA beats, one per input index, each carrying frame-boundary flags, that input's spike code and the NB-wide weight row for that input, on a valid/ready link. Sits directly upstream of the neuron accumulator. Holds the NA×NB weight array internally, loaded through a simple write port.

---
 rtl/neuron_weight_sequencer_pkg.sv | 35 +++
 rtl/neuron_weight_sequencer_weight_bank.sv | 31 +++
 rtl/neuron_weight_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/neuron_weight_sequencer_pkg.sv
// Shared beat layout, control-code width and sequencer FSM states.
// Beat layout, MSB first: {first, last, code[C-1:0], w[NB*WD-1:0]}.
package neuron_weight_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Rate-coded spikes carry a 2-bit code; every other encoding uses 1 bit.
    function automatic int ctrl_width(input logic is_rc);
        return is_rc ? 2 : 1;
    endfunction

    function automatic int w_lsb();
        return 0;
    endfunction

    function automatic int code_lsb(input int nb, input int wd);
        return nb * wd;
    endfunction

    function automatic int last_bit(input int c, input int nb, input int wd);
        return nb * wd + c;
    endfunction

    function automatic int first_bit(input int c, input int nb, input int wd);
        return nb * wd + c + 1;
    endfunction

    function automatic int beat_width(input int c, input int nb, input int wd);
        return nb * wd + c + 2;
    endfunction

endpackage

// File: rtl/neuron_weight_sequencer_weight_bank.sv
// NA x RW weight row store: one synchronous write port, one combinational read port.
// Reads see the pre-edge contents, so a same-edge write is not visible to that read.
module neuron_weight_sequencer_weight_bank #(
    parameter int NA = 4,
    parameter int RW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [RW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [RW-1:0] rdata
);

    logic [RW-1:0] rows [NA];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NA; i++) begin
                rows[i] <= '0;
            end
        end else if (we && (int'(waddr) < NA)) begin
            rows[waddr] <= wdata;
        end
    end

    assign rdata = rows[raddr];

endmodule

// File: rtl/neuron_weight_sequencer.sv
// Captures one spike frame, then streams NA beats {first,last,code,weight row}; beat 0 valid one edge after accept.
// Output register advances only when empty or consumed; a new frame is taken on the edge the last beat leaves.
module neuron_weight_sequencer
    import neuron_weight_sequencer_pkg::*;
#(
    parameter int NA   = 4,
    parameter int NB   = 4,
    parameter int WD   = 4,
    parameter     TYPE = "rc",
    localparam int C   = ctrl_width(TYPE == "rc"),
    localparam int AW  = (NA > 1) ? $clog2(NA) : 1,
    localparam int BW  = beat_width(C, NB, WD)
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iValid_AM_Spike,
    output logic               oReady_AM_Spike,
    input  logic [NA*C-1:0]    iData_AM_Spike,
    output logic               oValid_BS_Ctrl_Weit,
    input  logic               iReady_BS_Ctrl_Weit,
    output logic [BW-1:0]      oData_BS_Ctrl_Weit,
    input  logic               iWe,
    input  logic [AW-1:0]      iWaddr,
    input  logic [NB*WD-1:0]   iWdata
);

    localparam int FIRST_BIT = first_bit(C, NB, WD);
    localparam int LAST_BIT  = last_bit(C, NB, WD);
    localparam int CODE_LSB  = code_lsb(NB, WD);
    localparam int W_LSB     = w_lsb();

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [NA*C-1:0]  frame;
    logic             out_vld;
    logic [BW-1:0]    out_dat;

    logic             load;
    logic             accept;
    logic [AW-1:0]    rd_row;
    logic [NB*WD-1:0] rd_dat;
    logic [C-1:0]     run_code;
    logic [BW-1:0]    beat;

    assign load            = !out_vld || iReady_BS_Ctrl_Weit;
    assign oReady_AM_Spike = (state == IDLE) && load;
    assign accept          = iValid_AM_Spike && oReady_AM_Spike;

    // In IDLE the only beat that can be loaded is beat 0 of the incoming frame.
    assign rd_row   = (state == IDLE) ? '0 : cnt;
    assign run_code = frame[int'(cnt)*C +: C];

    neuron_weight_sequencer_weight_bank #(
        .NA (NA),
        .RW (NB*WD),
        .AW (AW)
    ) u_weight_bank (
        .clk   (iCLK),
        .rst_n (iRST),
        .we    (iWe),
        .waddr (iWaddr),
        .wdata (iWdata),
        .raddr (rd_row),
        .rdata (rd_dat)
    );

    always_comb begin
        beat                   = '0;
        beat[FIRST_BIT]        = (state == IDLE);
        beat[LAST_BIT]         = (state == IDLE) ? (NA == 1) : (cnt == AW'(NA-1));
        beat[CODE_LSB +: C]    = (state == IDLE) ? iData_AM_Spike[C-1:0] : run_code;
        beat[W_LSB +: NB*WD]   = rd_dat;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state   <= IDLE;
            cnt     <= '0;
            frame   <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        frame   <= iData_AM_Spike;
                        out_vld <= 1'b1;
                        out_dat <= beat;
                        if (NA > 1) begin
                            state <= RUN;
                            cnt   <= AW'(1);
                        end else begin
                            cnt   <= '0;
                        end
                    end else if (load) begin
                        out_vld <= 1'b0;
                    end
                end
                RUN: begin
                    if (load) begin
                        out_vld <= 1'b1;
                        out_dat <= beat;
                        if (cnt == AW'(NA-1)) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign oValid_BS_Ctrl_Weit = out_vld;
    assign oData_BS_Ctrl_Weit  = out_dat;

endmodule
